// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Contents:
//   state_t                          FSM encoding (IDLE / READ / UPDATE)
//   DEFAULT_WIDTH                    default PC / address / instruction width
//   DEFAULT_PC_INC                   default PC step per fetch (16-bit words, byte addresses)
//   DEFAULT_TIMEOUT                  default READ cycles allowed without MemReady
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_PC_INC  = 2;
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
// Signals:
//   MemAddr   fetch -> mem   read address
//   MemRead   fetch -> mem   read request, held for every wait cycle
//   MemReady  mem -> fetch   MemData is valid this cycle
//   MemData   mem -> fetch   instruction word
// Modports: master (fetch unit side), slave (memory side).
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] MemAddr;
    logic             MemRead;
    logic             MemReady;
    logic [WIDTH-1:0] MemData;

    modport master (
        output MemAddr,
        output MemRead,
        input  MemReady,
        input  MemData
    );

    modport slave (
        input  MemAddr,
        input  MemRead,
        output MemReady,
        output MemData
    );

endinterface

// File: rtl/instr_fetch_unit_wait_counter.sv
// Wait-cycle counter used to bound how long a memory read may stall.
// Ports:
//   CLK        clock
//   Reset      synchronous active-low reset
//   i_clear    force the count back to zero
//   i_enable   count this cycle
//   o_expired  high during the enabled cycle that would be the TERMINAL-th one
module fetch_wait_counter
    import fetch_pkg::*;
#(
    parameter int TERMINAL = DEFAULT_TIMEOUT
) (
    input  logic CLK,
    input  logic Reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!Reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(TERMINAL))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires combinationally in the last allowed cycle so the owner can leave
    // its wait state on the same edge the count reaches TERMINAL.
    assign o_expired = i_enable && (r_count == CW'(TERMINAL - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads the word at the current PC, loads the
// instruction register, then asks the PC register to take PC + PC_INC.
// Ports:
//   CLK, Reset            clock, synchronous active-low reset
//   FetchStart            begin a fetch (only honoured in IDLE)
//   Abort                 cancel an in-flight read
//   PCValue               current PC from the PC register
//   mem                   instruction memory bus (master side)
//   IRout                 instruction register
//   PCNext / PCWriteReq   data / write-enable for the PC register
//   FetchDone             one-cycle pulse on successful fetch
//   FetchError            one-cycle pulse after a read timeout
//   Busy                  high whenever not IDLE
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PC_INC  = DEFAULT_PC_INC,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             FetchStart,
    input  logic             Abort,
    input  logic [WIDTH-1:0] PCValue,
    instr_fetch_unit_if.master mem,
    output logic [WIDTH-1:0] IRout,
    output logic [WIDTH-1:0] PCNext,
    output logic             PCWriteReq,
    output logic             FetchDone,
    output logic             FetchError,
    output logic             Busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_ir;
    logic             r_fetch_error;
    logic             w_wait_en;
    logic             w_wait_clr;
    logic             w_expired;
    logic             w_mem_read;
    logic             w_pc_write;
    logic             w_done;
    logic [WIDTH-1:0] w_pc_next;

    // Only genuine stall cycles count; Abort and MemReady take priority.
    assign w_wait_en  = (r_state == S_READ) && !Abort && !mem.MemReady;
    assign w_wait_clr = (r_state != S_READ);

    fetch_wait_counter #(
        .TERMINAL (TIMEOUT)
    ) u_wait_counter (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_clear   (w_wait_clr),
        .i_enable  (w_wait_en),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (FetchStart) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (Abort) begin
                    w_state_next = S_IDLE;
                end else if (mem.MemReady) begin
                    w_state_next = S_UPDATE;
                end else if (w_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            S_UPDATE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_mem_read = 1'b0;
        w_pc_write = 1'b0;
        w_done     = 1'b0;
        w_pc_next  = '0;
        case (r_state)
            S_READ: w_mem_read = 1'b1;
            S_UPDATE: begin
                w_pc_write = 1'b1;
                w_done     = 1'b1;
                // Wraps silently modulo 2^WIDTH.
                w_pc_next  = r_addr + WIDTH'(PC_INC);
            end
            default: ;
        endcase
    end

    // Address / instruction / error registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_addr        <= '0;
            r_ir          <= '0;
            r_fetch_error <= 1'b0;
        end else begin
            // w_expired already excludes Abort and MemReady, so this pulses
            // only for a true timeout, in the cycle after the last READ.
            r_fetch_error <= w_expired;
            if ((r_state == S_IDLE) && FetchStart) begin
                r_addr <= PCValue;
            end
            if ((r_state == S_READ) && !Abort && mem.MemReady) begin
                r_ir <= mem.MemData;
            end
        end
    end

    assign mem.MemAddr = r_addr;
    assign mem.MemRead = w_mem_read;
    assign IRout       = r_ir;
    assign PCNext      = w_pc_next;
    assign PCWriteReq  = w_pc_write;
    assign FetchDone   = w_done;
    assign FetchError  = r_fetch_error;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer for the accumulator processor. It consumes the current PC value from the PC register and runs a handshaked read from instruction memory. It latches the returned word into the instruction register, then drives the PC register's write-enable and data input with the incremented PC. It is the reader and updater on the far side of the PC register interface; the control unit starts each fetch and can abort it.

## Interface
Parameters:
- WIDTH, 16, PC, address and instruction width
- PC_INC, 2, PC increment per fetch (byte-addressed, 16-bit words)
- TIMEOUT, 15, maximum READ cycles without MemReady before error

Ports:
- CLK  input  1  system clock, all state updates on posedge
- Reset  input  1  synchronous, active-low reset
- FetchStart  input  1  control request to begin a fetch; honoured only in IDLE
- Abort  input  1  cancel an in-flight read (branch or redirect)
- PCValue  input  WIDTH  current PC, taken from the PC register output
- MemAddr  output  WIDTH  instruction memory read address
- MemRead  output  1  memory read request
- MemReady  input  1  memory has valid data on MemData this cycle
- MemData  input  WIDTH  instruction word from memory
- IRout  output  WIDTH  instruction register
- PCNext  output  WIDTH  value for the PC register data input
- PCWriteReq  output  1  write-enable pulse for the PC register
- FetchDone  output  1  one-cycle pulse: IR and PC updated
- FetchError  output  1  one-cycle pulse: timeout, nothing updated
- Busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, READ, UPDATE.
- IDLE: if FetchStart=1, latch PCValue into the address register, clear the wait counter, and go to READ. Otherwise stay in IDLE.
- READ:
  - MemRead=1 and MemAddr=address register for every READ cycle.
  - Priority: Abort > MemReady > timeout.
  - Abort=1: go to IDLE. IR is unchanged and no PC write occurs.
  - MemReady=1: IRout<=MemData and go to UPDATE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, go to IDLE with FetchError=1 in the following cycle; IR and PC are untouched.
- UPDATE: PCWriteReq=1, PCNext=address register+PC_INC (mod 2^WIDTH), FetchDone=1, then go to IDLE. Abort is ignored in UPDATE.
- Wrap-around: address 0xFFFE with PC_INC=2 gives PCNext=0x0000. There is no carry or flag.
- MemRead, PCWriteReq, FetchDone and Busy are decoded from state. PCNext is driven only while PCWriteReq=1 and is 0 otherwise.
- FetchStart while Busy is ignored and is not queued.

## Timing
- Reset (Reset=0 at a posedge): state goes to IDLE. IRout, MemAddr, PCNext and the counter go to 0. MemRead, PCWriteReq, FetchDone, FetchError and Busy go to 0. Reset mid-READ or mid-UPDATE drops the transaction with no PC write.
- FetchStart sampled at edge 0: READ during cycle 1.
- MemReady high in cycle 1: IR is valid after edge 1, UPDATE runs in cycle 2, IDLE resumes in cycle 3.
- Minimum start-to-start spacing is 3 cycles.
- Each extra memory wait cycle adds 1 cycle of latency.
- Timeout: after TIMEOUT consecutive READ cycles without MemReady, FetchError is high for the single cycle after the last READ cycle.
- PCWriteReq and FetchDone are high for exactly 1 cycle per successful fetch.

## Structure
- Shared package `fetch_pkg`:
  - state encoding constants S_IDLE=2'd0, S_READ=2'd1, S_UPDATE=2'd2
  - default PC_INC and TIMEOUT constants
- One sub-module, `fetch_wait_counter`:
  - clear/enable inputs
  - parameterised terminal count
  - single-cycle `expired` output
  - instantiated once for the READ timeout.

## Test plan
- Reset then single fetch: PCValue=0x0010, FetchStart pulse, MemReady in the first READ cycle with MemData=0xA5C3. Required: IRout=0xA5C3, PCWriteReq pulse with PCNext=0x0012, FetchDone pulse, Busy high for exactly 2 cycles.
- Wait states: MemReady delayed 4 cycles. Required: MemRead held for 5 cycles, MemAddr stable, FetchDone 4 cycles later than the zero-wait case.
- Timeout: MemReady never asserted. Required: FetchError pulse after 15 READ cycles, no PCWriteReq, IRout retains its previous value.
- Abort in the same cycle as MemReady (MemData=0x1234). Required: return to IDLE, IRout unchanged, no PCWriteReq, no FetchDone.
- Wrap-around and ignored start: PCValue=0xFFFE fetch gives PCNext=0x0000. FetchStart re-pulsed during READ is ignored, giving exactly one FetchDone.
- Reset asserted (Reset=0) during UPDATE. Required: no further PCWriteReq, and all outputs 0 on the next cycle.
